// File: rtl/cache_mem_arbiter.sv
// Shares one multi-cycle main memory between the I-cache and D-cache miss paths.
// Latency: block fill takes 14 cycles from request to the cycle after done; a store takes 3.
// Backpressure: losers are held off through their stall outputs; D-side always wins a tie.
module cache_mem_arbiter #(
   parameter int BLOCK_WORDS = 8,
   parameter int ADDR_W      = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           icache_req,
   input  logic [ADDR_W-1:0]              icache_addr,
   input  logic                           dcache_req,
   input  logic                           dcache_wr,
   input  logic [ADDR_W-1:0]              dcache_addr,
   input  logic [15:0]                    dcache_wdata,
   output logic                           mem_en,
   output logic                           mem_wr,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [15:0]                    mem_wdata,
   input  logic [15:0]                    mem_rdata,
   input  logic                           mem_data_valid,
   output logic [15:0]                    fill_data,
   output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
   output logic                           icache_fill_we,
   output logic                           dcache_fill_we,
   output logic                           icache_done,
   output logic                           dcache_done,
   output logic                           icache_stall,
   output logic                           dcache_stall,
   output logic                           busy
);

   // Word index width, counter width (one extra bit so it can hold BLOCK_WORDS),
   // and width of the block base (address minus word index and byte-in-word bit).
   localparam int WB     = $clog2(BLOCK_WORDS);
   localparam int CW     = WB + 1;
   localparam int BASE_W = ADDR_W - WB - 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(BLOCK_WORDS);
   localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                owner_d_q, owner_d_d;   // 1 = D-cache owns the transaction
   logic [BASE_W-1:0]   base_q, base_d;
   logic [CW-1:0]       ic_q, ic_d;             // reads issued
   logic [CW-1:0]       rc_q, rc_d;             // returns accepted
   logic                fill_acc;

   // Only the block-select bits of the miss addresses are needed for a fill.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{icache_addr[WB:0], dcache_addr[WB:0]};

   // A return is accepted only while filling and before the block is complete;
   // anything else on mem_data_valid is a stale or spurious return.
   assign fill_acc = (state_q == S_FILL) && mem_data_valid && (rc_q < CNT_FULL);

   // State, owner, captured base and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         owner_d_q <= 1'b0;
         base_q    <= '0;
         ic_q      <= '0;
         rc_q      <= '0;
      end else begin
         state_q   <= state_d;
         owner_d_q <= owner_d_d;
         base_q    <= base_d;
         ic_q      <= ic_d;
         rc_q      <= rc_d;
      end
   end

   // Grant arbitration (D before I) and transaction sequencing.
   always_comb begin
      state_d   = state_q;
      owner_d_d = owner_d_q;
      base_d    = base_q;
      ic_d      = ic_q;
      rc_d      = rc_q;
      case (state_q)
         S_IDLE: begin
            if (dcache_req) begin
               state_d   = dcache_wr ? S_WRITE : S_FILL;
               owner_d_d = 1'b1;
               base_d    = dcache_addr[ADDR_W-1:WB+1];
               ic_d      = '0;
               rc_d      = '0;
            end else if (icache_req) begin
               state_d   = S_FILL;
               owner_d_d = 1'b0;
               base_d    = icache_addr[ADDR_W-1:WB+1];
               ic_d      = '0;
               rc_d      = '0;
            end
         end
         S_FILL: begin
            if (ic_q < CNT_FULL) begin
               ic_d = ic_q + 1'b1;
            end
            if (fill_acc) begin
               rc_d = rc_q + 1'b1;
               if (rc_q == CNT_LAST) begin
                  state_d = S_DONE;
               end
            end
         end
         S_WRITE: begin
            state_d   = S_DONE;
            owner_d_d = 1'b1;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Memory strobes, fill writes and done pulses decoded from state and counters.
   always_comb begin
      mem_en         = 1'b0;
      mem_wr         = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      fill_word      = '0;
      icache_fill_we = 1'b0;
      dcache_fill_we = 1'b0;
      icache_done    = 1'b0;
      dcache_done    = 1'b0;
      case (state_q)
         S_FILL: begin
            if (ic_q < CNT_FULL) begin
               mem_en   = 1'b1;
               mem_addr = {base_q, ic_q[WB-1:0], 1'b0};
            end
            if (fill_acc) begin
               fill_word      = rc_q[WB-1:0];
               icache_fill_we = ~owner_d_q;
               dcache_fill_we = owner_d_q;
            end
         end
         S_WRITE: begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = dcache_addr;
            mem_wdata = dcache_wdata;
         end
         S_DONE: begin
            icache_done = ~owner_d_q;
            dcache_done = owner_d_q;
         end
         default: begin
         end
      endcase
   end

   assign fill_data    = mem_rdata;
   assign icache_stall = icache_req & ~icache_done;
   assign dcache_stall = dcache_req & ~dcache_done;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a 4-cycle read-latency memory model.
// Fill writes are checked against a queue of expected (owner, word, data) entries.
// Cycle numbering in each test: cycle 0 is the IDLE cycle that first sees the request.
module tb_cache_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        icache_req;
   logic [15:0] icache_addr;
   logic        dcache_req;
   logic        dcache_wr;
   logic [15:0] dcache_addr;
   logic [15:0] dcache_wdata;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_data_valid;
   logic [15:0] fill_data;
   logic [2:0]  fill_word;
   logic        icache_fill_we;
   logic        dcache_fill_we;
   logic        icache_done;
   logic        dcache_done;
   logic        icache_stall;
   logic        dcache_stall;
   logic        busy;

   always #5 clk = ~clk;

   cache_mem_arbiter #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .icache_req     (icache_req),
      .icache_addr    (icache_addr),
      .dcache_req     (dcache_req),
      .dcache_wr      (dcache_wr),
      .dcache_addr    (dcache_addr),
      .dcache_wdata   (dcache_wdata),
      .mem_en         (mem_en),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_data_valid (mem_data_valid),
      .fill_data      (fill_data),
      .fill_word      (fill_word),
      .icache_fill_we (icache_fill_we),
      .dcache_fill_we (dcache_fill_we),
      .icache_done    (icache_done),
      .dcache_done    (dcache_done),
      .icache_stall   (icache_stall),
      .dcache_stall   (dcache_stall),
      .busy           (busy)
   );

   // Memory model: a read issued in cycle N returns in cycle N+4 with data addr ^ 0x5A5A.
   // It is not reset by the DUT reset, so in-flight returns survive an abort.
   logic [3:0]  pv = 4'b0;
   logic [15:0] pd0 = 16'h1357, pd1 = 16'h1357, pd2 = 16'h1357, pd3 = 16'h1357;
   logic        spur_vld = 1'b0;

   always @(posedge clk) begin
      pv  <= {pv[2:0], mem_en & ~mem_wr};
      pd0 <= mem_addr ^ 16'h5A5A;
      pd1 <= pd0;
      pd2 <= pd1;
      pd3 <= pd2;
   end

   assign mem_data_valid = pv[3] | spur_vld;
   assign mem_rdata      = pd3;

   typedef struct packed {
      logic        own_d;
      logic [2:0]  word;
      logic [15:0] data;
   } fill_t;

   fill_t exp_q[$];
   int    errors  = 0;
   int    checks  = 0;
   int    fills_i = 0;
   int    fills_d = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_fill(input logic own_d, input logic [15:0] addr);
      fill_t e;
      for (int w = 0; w < 8; w++) begin
         e.own_d = own_d;
         e.word  = w[2:0];
         e.data  = {addr[15:4], w[2:0], 1'b0} ^ 16'h5A5A;
         exp_q.push_back(e);
      end
   endtask

   // Every fill write is compared against the head of the expectation queue.
   task automatic monitor();
      fill_t e;
      forever begin
         @(negedge clk);
         if (icache_fill_we || dcache_fill_we) begin
            if (icache_fill_we) fills_i++;
            if (dcache_fill_we) fills_d++;
            chk("fill_unexpected", {31'd0, exp_q.size() == 0}, 32'd0);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("fill_write",
                   {10'd0, dcache_fill_we, icache_fill_we, fill_word, fill_data},
                   {10'd0, e.own_d, ~e.own_d, e.word, e.data});
            end
         end
      end
   endtask

   initial begin
      rst          = 1'b1;
      icache_req   = 1'b0;
      icache_addr  = 16'h0;
      dcache_req   = 1'b0;
      dcache_wr    = 1'b0;
      dcache_addr  = 16'h0;
      dcache_wdata = 16'h0;
      fork
         monitor();
      join_none

      // Reset state.
      step(2);
      chk("rst_outputs",
          {mem_en, mem_wr, fill_word, icache_fill_we, dcache_fill_we, icache_done,
           dcache_done, icache_stall, dcache_stall, busy, mem_addr, mem_wdata != 16'h0},
          32'd0);
      chk("rst_fill_data", {16'd0, fill_data}, {16'd0, mem_rdata});
      rst = 1'b0;

      // I-cache miss at 0x1236 with the D side idle.
      step(1);
      icache_req  = 1'b1;
      icache_addr = 16'h1236;
      push_fill(1'b0, 16'h1236);
      #1;
      chk("i_c0_busy_stall", {30'd0, busy, icache_stall}, 32'd1);
      for (int c = 1; c <= 8; c++) begin
         step(1);
         chk("i_issue_addr", {mem_en, mem_wr, 14'd0, mem_addr},
             {1'b1, 1'b0, 14'd0, 16'h1230 + 16'(2 * (c - 1))});
      end
      step(1);
      chk("i_c9_no_issue", {31'd0, mem_en}, 32'd0);
      step(3);
      chk("i_c12_done", {30'd0, icache_done, busy}, 32'd1);
      step(1);
      chk("i_c13_done", {29'd0, icache_done, dcache_done, icache_stall}, 32'd4);
      icache_req = 1'b0;
      step(1);
      chk("i_c14_idle", {30'd0, busy, icache_done}, 32'd0);
      chk("i_queue_empty", exp_q.size(), 32'd0);

      // Simultaneous D fill at 0x4000 and I fill at 0x2468: D is served first.
      step(1);
      icache_req  = 1'b1;
      icache_addr = 16'h2468;
      dcache_req  = 1'b1;
      dcache_wr   = 1'b0;
      dcache_addr = 16'h4000;
      push_fill(1'b1, 16'h4000);
      push_fill(1'b0, 16'h2468);
      step(1);
      chk("tie_c1_addr", {16'd0, mem_addr}, 32'h4000);
      chk("tie_c1_stalls", {30'd0, icache_stall, dcache_stall}, 32'd3);
      step(12);
      chk("tie_c13_ddone", {29'd0, dcache_done, icache_done, icache_stall}, 32'd5);
      dcache_req = 1'b0;
      step(1);
      chk("tie_c14_idle", {29'd0, busy, icache_stall, dcache_stall}, 32'd2);
      step(1);
      chk("tie_c15_igrant", {15'd0, busy, mem_addr}, {15'd0, 1'b1, 16'h2460});
      step(11);
      chk("tie_c26_stall", {30'd0, icache_done, icache_stall}, 32'd1);
      step(1);
      chk("tie_c27_idone", {30'd0, icache_done, icache_stall}, 32'd2);
      icache_req = 1'b0;
      step(1);
      chk("tie_c28_idle", {31'd0, busy}, 32'd0);
      chk("tie_queue_empty", exp_q.size(), 32'd0);

      // Write-through store of 0xBEEF to 0x0010.
      step(1);
      dcache_req   = 1'b1;
      dcache_wr    = 1'b1;
      dcache_addr  = 16'h0010;
      dcache_wdata = 16'hBEEF;
      step(1);
      chk("wr_c1_strobe", {mem_en, mem_wr, dcache_done, busy, 12'd0, mem_addr},
          {4'b1101, 12'd0, 16'h0010});
      chk("wr_c1_wdata", {16'd0, mem_wdata}, 32'h0000BEEF);
      step(1);
      chk("wr_c2_done", {28'd0, dcache_done, mem_en, dcache_stall, busy}, 32'd9);
      dcache_req = 1'b0;
      dcache_wr  = 1'b0;
      step(1);
      chk("wr_c3_idle", {31'd0, busy}, 32'd0);

      // Reset asserted in cycle 6 of an I fill at 0x0A5C and held through cycle 9.
      step(1);
      icache_req  = 1'b1;
      icache_addr = 16'h0A5C;
      push_fill(1'b0, 16'h0A5C);
      step(6);
      rst = 1'b1;
      #1;
      chk("rst_mid_idle", {31'd0, busy}, 32'd0);
      step(1);
      chk("rst_c7_outputs",
          {mem_en, mem_wr, fill_word, icache_fill_we, dcache_fill_we, icache_done,
           dcache_done, busy, mem_addr, 6'd0},
          32'd0);
      chk("rst_c7_stall", {31'd0, icache_stall}, 32'd1);
      step(2);
      rst = 1'b0;
      exp_q.delete();
      push_fill(1'b0, 16'h0A5C);
      step(1);
      chk("rst_regrant", {15'd0, busy, mem_addr}, {15'd0, 1'b1, 16'h0A50});
      step(12);
      chk("rst_refill_done", {30'd0, icache_done, busy}, 32'd3);
      icache_req = 1'b0;
      step(1);
      chk("rst_refill_idle", {31'd0, busy}, 32'd0);
      chk("rst_queue_empty", exp_q.size(), 32'd0);

      // Spurious return while IDLE, then a ninth return during DONE of a D fill.
      step(1);
      spur_vld = 1'b1;
      #1;
      chk("spur_idle", {29'd0, icache_fill_we, dcache_fill_we, busy}, 32'd0);
      step(1);
      spur_vld = 1'b0;
      chk("spur_idle_next", {31'd0, busy}, 32'd0);
      dcache_req  = 1'b1;
      dcache_wr   = 1'b0;
      dcache_addr = 16'h7770;
      push_fill(1'b1, 16'h7770);
      step(13);
      spur_vld = 1'b1;
      #1;
      chk("spur_done", {29'd0, dcache_fill_we, dcache_done, busy}, 32'd3);
      dcache_req = 1'b0;
      step(1);
      spur_vld = 1'b0;
      chk("spur_done_next", {31'd0, busy}, 32'd0);
      chk("spur_queue_empty", exp_q.size(), 32'd0);

      // Fill-write totals: 8 + 8 + (1 aborted + 8) on I, 8 + 8 on D.
      chk("total_fills_i", fills_i, 32'd25);
      chk("total_fills_d", fills_d, 32'd16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single multi-cycle main memory between the I-cache and D-cache miss paths in the pipelined processor. It grants one requester at a time, sequences an 8-word block fill or a single-word write-through store, and routes returned words into the owning cache. It drives per-cache stall signals that the pipeline OR-s with the hazard-unit stall.

## Interface
- BLOCK_WORDS, 8: 16-bit words per cache block; fixes the word-counter width at 3 bits.
- ADDR_W, 16: byte-address width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- icache_req  in  1  I-cache miss; held high until icache_done.
- icache_addr  in  16  miss byte address; bits [15:4] select the block.
- dcache_req  in  1  D-cache miss or store; held high until dcache_done.
- dcache_wr  in  1  1 = single-word write-through; 0 = block fill.
- dcache_addr  in  16  byte address.
- dcache_wdata  in  16  store data.
- mem_en  out  1  memory access strobe, one access per cycle.
- mem_wr  out  1  write enable, qualified by mem_en.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data.
- mem_data_valid  in  1  mem_rdata is valid; asserted 4 cycles after each read issue.
- fill_data  out  16  equals mem_rdata.
- fill_word  out  3  word index within the block for the current fill write.
- icache_fill_we  out  1  write fill_data into the I-cache at fill_word.
- dcache_fill_we  out  1  write fill_data into the D-cache at fill_word.
- icache_done  out  1  one-cycle pulse: I transaction complete.
- dcache_done  out  1  one-cycle pulse: D transaction complete.
- icache_stall  out  1  icache_req & ~icache_done.
- dcache_stall  out  1  dcache_req & ~dcache_done.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, FILL, WRITE, DONE. Owner register: I or D.
- IDLE, evaluated in priority order:
  - dcache_req & dcache_wr -> WRITE.
  - dcache_req -> FILL with owner D.
  - icache_req -> FILL with owner I.
  - D always wins ties because the D-cache miss belongs to an older instruction.
- On grant, capture base = addr[15:4] and clear both counters. Address changes after grant are ignored.
- FILL issue side:
  - While issue counter ic < 8: mem_en = 1, mem_wr = 0, mem_addr = {base, ic, 1'b0}.
  - ic increments each cycle.
  - ic is a 4-bit counter and saturates at 8.
- FILL return side:
  - On mem_data_valid, the owner's fill_we = 1 and fill_word = rc[2:0]; then rc increments.
  - When the return with rc == 7 arrives, go to DONE.
- WRITE:
  - One cycle with mem_en = 1, mem_wr = 1, mem_addr = dcache_addr, mem_wdata = dcache_wdata.
  - Then go to DONE with owner D.
- DONE: one cycle. The owner's done pulse is high. Requests are not sampled. Next state is IDLE.
- mem_data_valid is ignored outside FILL and after rc reaches 8. No fill_we is asserted in those cases.
- A losing requester keeps its stall high until it is served. No starvation bound is guaranteed for the I-side.

## Timing
- Reset (async): state = IDLE, owner = I, ic = rc = 0, base = 0.
  - Every output = 0, except fill_data, which follows mem_rdata.
  - Stalls follow the req inputs.
- Reset mid-transaction aborts it:
  - No done pulse is generated.
  - Memory returns still in flight are ignored because the block is in IDLE.
  - The requester, still holding req, is re-granted after reset deasserts.
- Fill timeline, request seen in IDLE at cycle 0:
  - Reads issue in cycles 1–8.
  - Returns arrive in cycles 5–12.
  - DONE is cycle 13; IDLE is cycle 14.
  - Total: 14 cycles from request to the cycle after the done pulse.
- Write timeline: WRITE at cycle 1, done pulse at cycle 2.
- A new request seen in the IDLE cycle right after DONE is granted at once. There are no dead cycles beyond DONE.
- fill_we, fill_word, mem_* and the stalls are combinational from state and counters. The done pulses are decoded from the DONE state.

## Test plan
- I miss at 0x1236, D idle -> mem_addr 0x1230, 0x1232, …, 0x123E in cycles 1–8; icache_fill_we ×8 with fill_word 0–7; icache_done at cycle 13; dcache_fill_we never asserted.
- icache_req and dcache_req (fill, 0x4000) both rise in the same cycle -> D filled first, dcache_done at 13; I granted at 14, icache_done at 27; icache_stall held high throughout.
- D store dcache_wr = 1, addr 0x0010, data 0xBEEF -> a single cycle of mem_en = mem_wr = 1 with mem_addr 0x0010, mem_wdata 0xBEEF; dcache_done next cycle; no fill_we.
- rst pulsed at cycle 6 of an I fill, with a return arriving at cycle 7 -> all outputs 0 and no fill_we at cycle 7; refill restarts from word 0 and completes normally.
- Spurious mem_data_valid while IDLE, plus a ninth return during DONE -> no fill_we, no state change.
